// File: rtl/axis_integrator.sv
// rtl/axis_integrator.sv - leaky, saturating stream integrator with registered AXI-Stream output
//
// Purpose: accumulates signed input samples (optionally leaking by 2^-leak_shift),
// saturates the accumulator, and emits a scaled and clamped copy of it per sample.
// Ports:
//   aclk, aresetn             clock, asynchronous active-low reset
//   enable                    1 = integrate, 0 = bypass (accumulator held at 0)
//   clear                     synchronous accumulator/overflow clear
//   leak_shift, out_shift     leak coefficient exponent, output right shift
//   S_AXIS_tvalid/tdata/tready   input sample stream
//   M_AXIS_tvalid/tdata/tready   output result stream
//   overflow                  sticky accumulator saturation flag
module axis_integrator #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int ACC_WIDTH        = 48
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        enable,
    input  logic                        clear,
    input  logic [5:0]                  leak_shift,
    input  logic [5:0]                  out_shift,
    input  logic                        S_AXIS_tvalid,
    input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
    output logic                        S_AXIS_tready,
    input  logic                        M_AXIS_tready,
    output logic                        M_AXIS_tvalid,
    output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
    output logic                        overflow
);
    localparam int         SW     = ACC_WIDTH + 2;
    localparam logic [5:0] MAX_SH = 6'(ACC_WIDTH - 1);

    logic signed [ACC_WIDTH-1:0]        r_acc;
    logic                               r_ovf;
    logic                               r_tvalid;
    logic [AXIS_TDATA_WIDTH-1:0]        r_tdata;

    logic                               w_accept;
    logic signed [ACC_WIDTH-1:0]        w_acc_base;
    logic signed [ACC_WIDTH-1:0]        w_leak;
    logic signed [SW-1:0]               w_sum;
    logic                               w_acc_sat;
    logic signed [ACC_WIDTH-1:0]        w_acc_next;
    logic [5:0]                         w_out_sh;
    logic signed [ACC_WIDTH-1:0]        w_shifted;
    logic [AXIS_TDATA_WIDTH-1:0]        w_out;

    // Upstream may only push when the output register is free or draining this cycle.
    assign S_AXIS_tready = aresetn & (~r_tvalid | M_AXIS_tready);
    assign w_accept      = S_AXIS_tvalid & S_AXIS_tready;

    always_comb begin
        // Clear takes effect before the add when both happen in the same cycle.
        w_acc_base = clear ? '0 : r_acc;

        w_leak = '0;
        if (leak_shift != 6'd0 && leak_shift < MAX_SH)
            w_leak = w_acc_base >>> leak_shift;

        // Two guard bits hold acc - leak + sample without wrapping.
        w_sum = {{2{w_acc_base[ACC_WIDTH-1]}}, w_acc_base}
              - {{2{w_leak[ACC_WIDTH-1]}}, w_leak}
              + {{(SW-AXIS_TDATA_WIDTH){S_AXIS_tdata[AXIS_TDATA_WIDTH-1]}}, S_AXIS_tdata};

        // The sum fits the accumulator only if its top three bits agree.
        w_acc_sat = !((&w_sum[SW-1:ACC_WIDTH-1]) || !(|w_sum[SW-1:ACC_WIDTH-1]));
        if (!w_acc_sat)
            w_acc_next = w_sum[ACC_WIDTH-1:0];
        else if (w_sum[SW-1])
            w_acc_next = {1'b1, {(ACC_WIDTH-1){1'b0}}};
        else
            w_acc_next = {1'b0, {(ACC_WIDTH-1){1'b1}}};

        w_out_sh  = (out_shift > MAX_SH) ? MAX_SH : out_shift;
        w_shifted = w_acc_next >>> w_out_sh;

        // Clamp the scaled accumulator into the output sample range.
        if ((&w_shifted[ACC_WIDTH-1:AXIS_TDATA_WIDTH-1]) || !(|w_shifted[ACC_WIDTH-1:AXIS_TDATA_WIDTH-1]))
            w_out = w_shifted[AXIS_TDATA_WIDTH-1:0];
        else if (w_shifted[ACC_WIDTH-1])
            w_out = {1'b1, {(AXIS_TDATA_WIDTH-1){1'b0}}};
        else
            w_out = {1'b0, {(AXIS_TDATA_WIDTH-1){1'b1}}};
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_acc    <= '0;
            r_ovf    <= 1'b0;
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
        end else begin
            if (!enable)
                r_acc <= '0;
            else if (w_accept)
                r_acc <= w_acc_next;
            else if (clear)
                r_acc <= '0;

            if (w_accept && enable)
                r_ovf <= (r_ovf && !clear) || w_acc_sat;
            else if (clear)
                r_ovf <= 1'b0;

            if (w_accept) begin
                r_tvalid <= 1'b1;
                r_tdata  <= enable ? w_out : S_AXIS_tdata;
            end else if (M_AXIS_tready) begin
                r_tvalid <= 1'b0;
            end
        end
    end

    assign M_AXIS_tvalid = r_tvalid;
    assign M_AXIS_tdata  = r_tdata;
    assign overflow      = r_ovf;

endmodule

// File: tb/tb_axis_integrator.sv
// tb/tb_axis_integrator.sv - scoreboard testbench for axis_integrator
module tb_axis_integrator;
    localparam int DW = 32;
    localparam int AW = 34;
    localparam longint OMAX = 64'sd2147483647;
    localparam longint OMIN = -64'sd2147483648;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b1;
    logic          enable = 1'b1;
    logic          clear = 1'b0;
    logic [5:0]    leak_shift = 6'd0;
    logic [5:0]    out_shift = 6'd0;
    logic          s_tvalid = 1'b0;
    logic [DW-1:0] s_tdata = '0;
    logic          s_tready;
    logic          m_tready = 1'b1;
    logic          m_tvalid;
    logic [DW-1:0] m_tdata;
    logic          overflow;

    axis_integrator #(.AXIS_TDATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
        .aclk(aclk), .aresetn(aresetn), .enable(enable), .clear(clear),
        .leak_shift(leak_shift), .out_shift(out_shift),
        .S_AXIS_tvalid(s_tvalid), .S_AXIS_tdata(s_tdata), .S_AXIS_tready(s_tready),
        .M_AXIS_tready(m_tready), .M_AXIS_tvalid(m_tvalid), .M_AXIS_tdata(m_tdata),
        .overflow(overflow)
    );

    always #5 aclk = ~aclk;

    int     checks = 0;
    int     failures = 0;
    int     cyc = 0;
    longint exp_q[$];
    longint got[$];
    int     got_cyc[$];
    int     acc_cyc[$];
    longint m_acc = 0;
    bit     m_ovf = 1'b0;
    bit     rnd_done;

    longint e25[4] = '{1, 3, 6, 10};
    longint e27[9] = '{100, 150, 175, 188, 194, 197, 199, 200, 200};

    task automatic check(input string tag, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    always @(posedge aclk) cyc <= cyc + 1;

    // Reference model and output monitor; both look at the signals that will be
    // sampled by the next rising edge.
    always @(negedge aclk) begin
        longint acc_in, leak, sum, sat, o, e, a;
        bit     ovf_in, sflag;
        int     os;
        if (!aresetn) begin
            exp_q.delete();
            m_acc = 0;
            m_ovf = 1'b0;
        end else begin
            check("ovf", longint'(overflow), longint'(m_ovf));
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    check("out_queued", longint'(exp_q.size()), 1);
                end else begin
                    e = exp_q.pop_front();
                    a = longint'($signed(m_tdata));
                    check("out", a, e);
                    got.push_back(a);
                    got_cyc.push_back(cyc);
                end
            end
            acc_in = clear ? 0 : m_acc;
            ovf_in = clear ? 1'b0 : m_ovf;
            if (s_tvalid && s_tready) begin
                acc_cyc.push_back(cyc);
                if (enable) begin
                    leak = (leak_shift == 0 || int'(leak_shift) >= AW - 1) ? 0 : (acc_in >>> leak_shift);
                    sum = acc_in - leak + longint'($signed(s_tdata));
                    sflag = 1'b0;
                    sat = sum;
                    if (sum > (longint'(1) <<< (AW - 1)) - 1) begin
                        sat = (longint'(1) <<< (AW - 1)) - 1;
                        sflag = 1'b1;
                    end else if (sum < -(longint'(1) <<< (AW - 1))) begin
                        sat = -(longint'(1) <<< (AW - 1));
                        sflag = 1'b1;
                    end
                    os = (int'(out_shift) > AW - 1) ? AW - 1 : int'(out_shift);
                    o = sat >>> os;
                    if (o > OMAX) o = OMAX;
                    else if (o < OMIN) o = OMIN;
                    exp_q.push_back(o);
                    m_acc = sat;
                    m_ovf = ovf_in | sflag;
                end else begin
                    exp_q.push_back(longint'($signed(s_tdata)));
                    m_acc = 0;
                    m_ovf = ovf_in;
                end
            end else begin
                m_acc = enable ? acc_in : 0;
                m_ovf = ovf_in;
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input longint d, input bit clr = 1'b0);
        int n;
        n = 0;
        s_tvalid = 1'b1;
        s_tdata  = d[DW-1:0];
        clear    = clr;
        @(negedge aclk);
        while (!s_tready) begin
            n++;
            if (n > 200) begin
                check("send_timeout", longint'(n), 0);
                break;
            end
            @(negedge aclk);
        end
        @(posedge aclk);
        #1;
        s_tvalid = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_tvalid) && n < 400) begin
            @(posedge aclk);
            #1;
            n++;
        end
        check("drain", longint'(exp_q.size()), 0);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge aclk);
        #1;
        clear = 1'b0;
    endtask

    task automatic reset_log();
        got.delete();
        got_cyc.delete();
        acc_cyc.delete();
    endtask

    initial begin
        #2 aresetn = 1'b0;
        #1;
        check("rst_tvalid", longint'(m_tvalid), 0);
        check("rst_tdata", longint'(m_tdata), 0);
        check("rst_ovf", longint'(overflow), 0);
        check("rst_tready", longint'(s_tready), 0);
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
        @(posedge aclk);
        #1;

        // Back-to-back running sum, one result per cycle, one cycle after accept.
        reset_log();
        send(1); send(2); send(3); send(4);
        drain();
        check("r25_count", longint'(got.size()), 4);
        for (int i = 0; i < 4; i++) begin
            check("r25_val", got[i], e25[i]);
            check("r25_lat", longint'(got_cyc[i] - acc_cyc[i]), 1);
        end
        for (int i = 1; i < 4; i++)
            check("r25_rate", longint'(got_cyc[i] - got_cyc[i-1]), 1);

        // Backpressure on the first output.
        pulse_clear();
        reset_log();
        m_tready = 1'b0;
        fork
            begin
                send(1); send(2); send(3); send(4);
            end
            begin
                int n;
                n = 0;
                @(negedge aclk);
                while (!m_tvalid && n < 50) begin
                    n++;
                    @(negedge aclk);
                end
                for (int k = 0; k < 3; k++) begin
                    check("r26_stall_tready", longint'(s_tready), 0);
                    check("r26_hold", longint'($signed(m_tdata)), 1);
                    if (k < 2) @(negedge aclk);
                end
                @(posedge aclk);
                #1 m_tready = 1'b1;
            end
        join
        drain();
        check("r26_count", longint'(got.size()), 4);
        for (int i = 0; i < 4; i++)
            check("r26_val", got[i], e25[i]);

        // Leaky integration of a constant.
        pulse_clear();
        reset_log();
        leak_shift = 6'd1;
        for (int i = 0; i < 9; i++) send(100);
        drain();
        check("r27_count", longint'(got.size()), 9);
        for (int i = 0; i < 9; i++)
            check("r27_val", got[i], e27[i]);
        leak_shift = 6'd0;

        // Accumulator and output saturation.
        pulse_clear();
        reset_log();
        for (int i = 0; i < 5; i++) send(longint'(32'h7FFF_FFFF));
        drain();
        for (int i = 0; i < 5; i++)
            check("r28_outsat", got[i], 64'sd2147483647);
        check("r28_ovf_set", longint'(overflow), 1);
        out_shift = 6'd3;
        send(0);
        drain();
        check("r28_acc_max", got[5], 64'sd1073741823);
        out_shift = 6'd0;
        pulse_clear();
        check("r28_ovf_clr", longint'(overflow), 0);

        // Clear coinciding with accept, bypass, re-enable.
        pulse_clear();
        reset_log();
        send(10);
        send(5, 1'b1);
        drain();
        check("r29_clear_add", got[1], 5);
        check("r29_ovf", longint'(overflow), 0);
        enable = 1'b0;
        send(-7);
        drain();
        check("r29_bypass", got[2], -7);
        check("r29_bypass_lat", longint'(got_cyc[2] - acc_cyc[2]), 1);
        enable = 1'b1;
        send(7);
        drain();
        check("r29_reenable", got[3], 7);

        // Reset while an output is pending.
        m_tready = 1'b0;
        send(9);
        #3 aresetn = 1'b0;
        #1;
        check("r30_tvalid", longint'(m_tvalid), 0);
        check("r30_tdata", longint'(m_tdata), 0);
        check("r30_ovf", longint'(overflow), 0);
        check("r30_tready", longint'(s_tready), 0);
        @(negedge aclk);
        @(posedge aclk);
        #1 aresetn = 1'b1;
        m_tready = 1'b1;
        reset_log();
        send(4);
        drain();
        check("r30_count", longint'(got.size()), 1);
        check("r30_first", got[0], 4);

        // Randomized traffic against the model with random backpressure.
        pulse_clear();
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    leak_shift = 6'($urandom_range(0, 40));
                    out_shift  = 6'($urandom_range(0, 40));
                    send(longint'($signed($urandom())), $urandom_range(0, 9) == 0);
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge aclk);
                        #1;
                    end
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge aclk);
                    #1 m_tready = ($urandom_range(0, 2) != 0);
                end
                m_tready = 1'b1;
            end
        join
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: time %0t limit %0d", $time, 500000);
        $fatal(1);
    end

endmodule

// File: doc/axis_integrator.md
AXIS_INTEGRATOR -- requirements
Module: axis_integrator

Interface
REQ-001 Parameter AXIS_TDATA_WIDTH, default 32, sets the sample width (signed two's complement) of both streams.
REQ-002 Parameter ACC_WIDTH, default 48, sets the signed accumulator width; legal range is ≥ AXIS_TDATA_WIDTH+2 and ≤ 63.
REQ-003 aclk  in  1  single clock; all state changes on its rising edge.
REQ-004 aresetn  in  1  asynchronous, active-low reset.
REQ-005 enable  in  1  1 = integrate, 0 = bypass with accumulator held at 0.
REQ-006 clear  in  1  synchronous accumulator and overflow clear.
REQ-007 leak_shift  in  6  leak coefficient 2^-leak_shift; 0 = no leak.
REQ-008 out_shift  in  6  arithmetic right shift applied to the accumulator before output.
REQ-009 S_AXIS_tvalid  in  1; S_AXIS_tdata  in  AXIS_TDATA_WIDTH; S_AXIS_tready  out  1: input stream.
REQ-010 M_AXIS_tready  in  1; M_AXIS_tvalid  out  1; M_AXIS_tdata  out  AXIS_TDATA_WIDTH: output stream.
REQ-011 overflow  out  1  sticky flag, set on any accumulator saturation.

Function
REQ-012 Accept = S_AXIS_tvalid && S_AXIS_tready; S_AXIS_tready SHALL equal (!M_AXIS_tvalid || M_AXIS_tready) while aresetn=1, and 0 while aresetn=0.
REQ-013 On accept with enable=1: leak = (leak_shift==0 or leak_shift ≥ ACC_WIDTH-1) ? 0 : acc >>> leak_shift; sum = acc - leak + sign_ext(S_AXIS_tdata), computed in ACC_WIDTH+2 bits.
REQ-014 acc_next SHALL be sum saturated to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]; when saturation occurs, overflow SHALL be set.
REQ-015 On accept, M_AXIS_tdata SHALL register enable ? sat_out(acc_next >>> min(out_shift, ACC_WIDTH-1)) : S_AXIS_tdata, where sat_out clamps to the signed AXIS_TDATA_WIDTH range; output saturation does not set overflow.
REQ-016 Latency: M_AXIS_tvalid SHALL rise on the cycle after accept and carry that sample's result; a sustained stream with M_AXIS_tready=1 SHALL run at one sample per cycle.
REQ-017 M_AXIS_tvalid SHALL clear when M_AXIS_tready=1 and no accept occurs that cycle; while M_AXIS_tvalid=1 and M_AXIS_tready=0, M_AXIS_tdata SHALL hold stable.
REQ-018 Without accept, acc SHALL hold (no leak is applied on idle cycles).
REQ-019 leak_shift and out_shift SHALL be used only on the accept cycle; changes between accepts have no other effect.
REQ-020 clear=1 SHALL zero acc and overflow; if clear coincides with accept, the add uses acc=0 (clear-then-add), and overflow reflects only that add.
REQ-021 enable=0 SHALL force acc to 0 every cycle while keeping the handshake and 1-cycle latency; on re-enable, integration restarts from 0.
REQ-022 M_AXIS_tvalid SHALL never be withdrawn before a handshake, and no sample SHALL be lost or duplicated under backpressure.

Reset
REQ-023 aresetn=0 SHALL immediately (asynchronously) force acc=0, M_AXIS_tvalid=0, M_AXIS_tdata=0, overflow=0, and S_AXIS_tready=0.
REQ-024 Reset mid-stream SHALL discard any pending output; the first sample after release starts from acc=0.

Verification
REQ-025 enable=1, leak_shift=0, out_shift=0, M_AXIS_tready=1; send 1,2,3,4 back-to-back -> outputs 1,3,6,10 on consecutive cycles, each one cycle after accept.
REQ-026 Same stimulus, M_AXIS_tready=0 after the first output for 3 cycles -> S_AXIS_tready=0, M_AXIS_tdata held at 1; after release -> 3,6,10 with no loss or duplication.
REQ-027 leak_shift=1, constant input 100 -> outputs 100,150,175,188,194,197,199,200,200.
REQ-028 ACC_WIDTH=34, out_shift=0; send 0x7FFFFFFF five times -> acc saturates at 2^33-1, overflow=1, output saturates at 0x7FFFFFFF; clear pulse -> overflow=0.
REQ-029 With acc=10, assert clear together with an accepted sample of 5 -> output 5, overflow=0; with enable=0, send -7 -> output -7 (0xFFFFFFF9) one cycle later; re-enable and send 7 -> output 7.
REQ-030 Assert aresetn=0 while M_AXIS_tvalid=1 -> all outputs 0 immediately; after release, send 4 -> output 4.
